// File: rtl/imem_stream_loader.sv
// Streams little-endian bytes into 32-bit instruction words for dnn_cpu, writing them from address 0.
// Holds the CPU in reset during the load, then releases reset and, after a delay, asserts enb.
module imem_stream_loader #(
    parameter int ADDR_W      = 7,
    parameter int RELEASE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_addr,
    output logic              inst_wen,
    output logic              cpu_rst,
    output logic              cpu_enb,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;

    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [3:0]      REL_LAST = 4'(RELEASE_CYC - 1);

    state_t            state;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   word_idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_buf;
    logic [3:0]        rel_cnt;
    logic              last_wr;
    logic [ADDR_W:0]   n_clamped;

    assign n_clamped = (num_words > DEPTH) ? DEPTH : num_words;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s_ready   <= 1'b0;
            inst_wen  <= 1'b0;
            inst_addr <= '0;
            inst_data <= '0;
            cpu_rst   <= 1'b1;
            cpu_enb   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            n_words   <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            word_buf  <= '0;
            rel_cnt   <= '0;
            last_wr   <= 1'b0;
        end else begin
            inst_wen <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (start) begin
                        n_words  <= n_clamped;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        last_wr  <= 1'b0;
                        done     <= 1'b0;
                        cpu_enb  <= 1'b0;
                        busy     <= 1'b1;
                        if (n_clamped == '0) begin
                            state   <= RELEASE;
                            cpu_rst <= 1'b0;
                            rel_cnt <= REL_LAST;
                        end else begin
                            state   <= LOAD;
                            cpu_rst <= 1'b1;
                            s_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // last_wr marks the final write cycle; reset is released right after it
                    if (last_wr) begin
                        state   <= RELEASE;
                        cpu_rst <= 1'b0;
                        rel_cnt <= REL_LAST;
                        last_wr <= 1'b0;
                    end else if (s_valid && s_ready) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= s_data;
                            2'd1: word_buf[15:8]  <= s_data;
                            2'd2: word_buf[23:16] <= s_data;
                            default: begin
                                inst_wen  <= 1'b1;
                                inst_addr <= word_idx[ADDR_W-1:0];
                                inst_data <= {s_data, word_buf};
                                word_idx  <= word_idx + 1'b1;
                                if (word_idx + 1'b1 == n_words) begin
                                    s_ready <= 1'b0;
                                    last_wr <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                RELEASE: begin
                    if (rel_cnt == 4'd0) begin
                        state   <= RUN;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cpu_enb <= 1'b1;
                    end else begin
                        rel_cnt <= rel_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: byte streams with hand-computed words and handshake timing.
module tb_imem_stream_loader;
    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   num_words;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       inst_data;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_wen;
    logic              cpu_rst;
    logic              cpu_enb;
    logic              busy;
    logic              done;

    int vecs = 0;
    int errs = 0;

    logic [7:0]        bytes_q[$];
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];

    imem_stream_loader #(.ADDR_W(ADDR_W), .RELEASE_CYC(1)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .inst_data(inst_data), .inst_addr(inst_addr), .inst_wen(inst_wen),
        .cpu_rst(cpu_rst), .cpu_enb(cpu_enb), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (inst_wen === 1'b1) begin
            wr_addr_q.push_back(inst_addr);
            wr_data_q.push_back(inst_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) bytes_q.push_back(w[8*k +: 8]);
        exp_q.push_back(w);
    endtask

    task automatic pulse_start(input logic [ADDR_W:0] n);
        start = 1'b1;
        num_words = n;
        tick();
        start = 1'b0;
        num_words = '0;
    endtask

    // Streams bytes_q; returns in the cycle after the last byte was accepted.
    task automatic send(input bit toggle);
        int  i = 0;
        int  guard = 0;
        bit  ph = 1'b1;
        logic xfer;
        while (i < bytes_q.size() && guard < 4000) begin
            s_data  = bytes_q[i];
            s_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            xfer = s_valid && s_ready;
            tick();
            if (xfer) i++;
            guard++;
        end
        s_valid = 1'b0;
        check("send_complete", i, bytes_q.size());
    endtask

    task automatic check_writes(input string tag, input int base);
        check({tag, "_count"}, wr_addr_q.size() - base, exp_q.size());
        for (int j = 0; j < exp_q.size() && base + j < wr_addr_q.size(); j++) begin
            check({tag, "_addr"}, wr_addr_q[base + j], j);
            check({tag, "_data"}, wr_data_q[base + j], exp_q[j]);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_s_ready"},   s_ready,   0);
        check({tag, "_inst_wen"},  inst_wen,  0);
        check({tag, "_inst_addr"}, inst_addr, 0);
        check({tag, "_inst_data"}, inst_data, 0);
        check({tag, "_cpu_rst"},   cpu_rst,   1);
        check({tag, "_cpu_enb"},   cpu_enb,   0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
    endtask

    initial begin
        int base;
        rst = 1'b1; start = 1'b0; num_words = '0; s_data = '0; s_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_idle_reset("por");

        // reset in the middle of a load, after one word was written
        pulse_start(2);
        check("load_busy", busy, 1);
        check("load_s_ready", s_ready, 1);
        bytes_q.delete(); exp_q.delete();
        push_word(32'hCAFE_F00D);
        bytes_q.push_back(8'h11); bytes_q.push_back(8'h22);
        send(1'b0);
        check("mid_addr_before_rst", inst_addr, 0);
        check("mid_data_before_rst", inst_data, 32'hCAFE_F00D);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_idle_reset("mid_load_rst");

        // two words, s_valid held high, exact release timing
        base = wr_addr_q.size();
        pulse_start(2);
        bytes_q.delete(); exp_q.delete();
        push_word(32'h0000_0013);
        push_word(32'h0010_0093);
        send(1'b0);
        check("last_wen", inst_wen, 1);
        check("last_s_ready_low", s_ready, 0);
        check("last_cpu_rst_held", cpu_rst, 1);
        tick();
        check("rel_wen_low", inst_wen, 0);
        check("rel_cpu_rst", cpu_rst, 0);
        check("rel_cpu_enb", cpu_enb, 0);
        check("rel_busy", busy, 1);
        check("rel_done", done, 0);
        tick();
        check("run_cpu_enb", cpu_enb, 1);
        check("run_done", done, 1);
        check("run_busy", busy, 0);
        check("run_addr_hold", inst_addr, 1);
        check("run_data_hold", inst_data, 32'h0010_0093);
        check_writes("two_words", base);

        // start in RUN restarts at addr 0; same data with s_valid toggling
        base = wr_addr_q.size();
        pulse_start(2);
        check("restart_cpu_enb", cpu_enb, 0);
        check("restart_cpu_rst", cpu_rst, 1);
        check("restart_done", done, 0);
        check("restart_s_ready", s_ready, 1);
        send(1'b1);
        tick(); tick();
        check("toggle_done", done, 1);
        check_writes("toggle", base);

        // start during LOAD is ignored (would otherwise begin an empty load)
        base = wr_addr_q.size();
        pulse_start(1);
        pulse_start(0);
        check("ign_busy", busy, 1);
        check("ign_s_ready", s_ready, 1);
        bytes_q.delete(); exp_q.delete();
        push_word(32'hDEAD_BEEF);
        send(1'b0);
        tick(); tick();
        check("ign_done", done, 1);
        check_writes("ign_start", base);

        // num_words beyond depth clamps to 128 words
        base = wr_addr_q.size();
        pulse_start(200);
        bytes_q.delete(); exp_q.delete();
        for (int w = 0; w < 128; w++) push_word({w[7:0] ^ 8'h5A, 8'hC3, w[7:0], 8'h01});
        send(1'b0);
        check("clamp_last_addr", inst_addr, 127);
        check("clamp_last_data", inst_data, 32'h25C3_7F01);
        tick(); tick();
        check("clamp_done", done, 1);
        check_writes("clamp", base);

        // empty load from IDLE: straight to RELEASE, RUN one cycle later
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base = wr_addr_q.size();
        pulse_start(0);
        check("empty_busy", busy, 1);
        check("empty_s_ready", s_ready, 0);
        check("empty_cpu_rst", cpu_rst, 0);
        check("empty_done_early", done, 0);
        tick();
        check("empty_done", done, 1);
        check("empty_cpu_enb", cpu_enb, 1);
        check("empty_no_writes", wr_addr_q.size() - base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
